// File: rtl/espectro_note_sequencer.sv
// espectro_note_sequencer: CPU-programmable note queue that masters the
// peripheral_espectro register port. Notes {FREQ_H, FREQ_L, DUR} are queued
// through the CPU register map; each one is written to FRh/FRl, held for DUR
// ticks and the tone is muted once the queue drains or on flush.
// Optional build macro: ESPECTRO_SEQ_LOOP_EN (CTRL bit2 loop playback).
module espectro_note_sequencer #(
    parameter int         DEPTH    = 8,
    parameter int         TICK_DIV = 50000,
    parameter int         WR_HOLD  = 4,
    parameter logic [3:0] FRH_ADDR = 4'h2,
    parameter logic [3:0] FRL_ADDR = 4'h4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs,
    input  logic [3:0]  addr,
    input  logic        rd,
    input  logic        wr,
    input  logic [15:0] d_in,
    output logic [15:0] d_out,
    output logic        sp_cs,
    output logic [3:0]  sp_addr,
    output logic        sp_rd,
    output logic        sp_wr,
    output logic [15:0] sp_d_in,
    output logic        busy
);
    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = PW + 1;
    localparam int PRW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HW  = (WR_HOLD > 1) ? $clog2(WR_HOLD) : 1;

    localparam logic [3:0] A_FREQ_H = 4'h2;
    localparam logic [3:0] A_FREQ_L = 4'h4;
    localparam logic [3:0] A_DUR    = 4'h6;
    localparam logic [3:0] A_CTRL   = 4'h8;
    localparam logic [3:0] A_STATUS = 4'hA;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_WR_H, S_WR_L, S_PLAY, S_MUTE_H, S_MUTE_L
    } state_t;

    state_t state, state_nx;

    logic [15:0] freq_h_stg, freq_l_stg;
    logic        ctrl_run, ctrl_loop, overflow;
    logic [15:0] cur_fh, cur_fl, cur_dur;
    logic [47:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [HW-1:0] hold_cnt;
    logic [PRW-1:0] pre_cnt;
    logic [15:0] tick_cnt;

    wire wr_en    = cs & wr;
    wire rd_en    = cs & rd;
    wire flush    = wr_en & (addr == A_CTRL) & d_in[1];
    wire cpu_push = wr_en & (addr == A_DUR);

    wire full  = (count == CW'(DEPTH));
    wire empty = (count == '0);
    wire [47:0] head = mem[rd_ptr];

    // LOAD always pops; in loop mode the popped entry goes straight back to the tail
    wire do_pop    = (state == S_LOAD);
    wire loop_push = do_pop & ctrl_loop;
    wire push_ok   = cpu_push & ~loop_push & (~full | do_pop);
    wire push_drop = cpu_push & ~push_ok;
    wire do_push   = push_ok | loop_push;
    wire [47:0] push_data = loop_push ? head : {freq_h_stg, freq_l_stg, d_in};

    wire hold_done = (hold_cnt == HW'(WR_HOLD - 1));
    wire pre_done  = (pre_cnt == PRW'(TICK_DIV - 1));
    wire [15:0] dur_last = (cur_dur == 16'd0) ? 16'd0 : cur_dur - 16'd1;
    wire expire    = pre_done & (tick_cnt == dur_last);

    // CPU-writable staging registers and run bit
    always_ff @(posedge clk) begin
        if (rst) begin
            freq_h_stg <= '0;
            freq_l_stg <= '0;
            ctrl_run   <= 1'b0;
        end else if (wr_en) begin
            case (addr)
                A_FREQ_H: freq_h_stg <= d_in;
                A_FREQ_L: freq_l_stg <= d_in;
                A_CTRL:   ctrl_run   <= d_in[0];
                default: ;
            endcase
        end
    end

`ifdef ESPECTRO_SEQ_LOOP_EN
    // loop bit: replay the queue indefinitely
    always_ff @(posedge clk) begin
        if (rst)
            ctrl_loop <= 1'b0;
        else if (wr_en && addr == A_CTRL)
            ctrl_loop <= d_in[2];
    end
`else
    assign ctrl_loop = 1'b0;
`endif

    // FIFO storage; contents need no reset, pointers and count do
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

    // FIFO pointers and occupancy; flush empties the queue in one cycle
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    // sticky overflow, cleared by a STATUS read (a new drop wins)
    always_ff @(posedge clk) begin
        if (rst)
            overflow <= 1'b0;
        else if (push_drop)
            overflow <= 1'b1;
        else if (rd_en && addr == A_STATUS)
            overflow <= 1'b0;
    end

    // registered CPU read data
    always_ff @(posedge clk) begin
        if (rst)
            d_out <= '0;
        else if (rd_en) begin
            case (addr)
                A_CTRL:   d_out <= {13'd0, ctrl_loop, 1'b0, ctrl_run};
                A_STATUS: d_out <= {8'd0, 4'(count), overflow, empty, full, busy};
                default:  d_out <= '0;
            endcase
        end else
            d_out <= '0;
    end

    // current note captured at LOAD
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_fh  <= '0;
            cur_fl  <= '0;
            cur_dur <= '0;
        end else if (state == S_LOAD) begin
            {cur_fh, cur_fl, cur_dur} <= head;
        end
    end

    // hold / prescaler / tick counters, cleared on every state change
    always_ff @(posedge clk) begin
        if (rst || state_nx != state) begin
            hold_cnt <= '0;
            pre_cnt  <= '0;
            tick_cnt <= '0;
        end else if (state == S_PLAY) begin
            if (pre_done) begin
                pre_cnt  <= '0;
                tick_cnt <= tick_cnt + 16'd1;
            end else
                pre_cnt <= pre_cnt + PRW'(1);
        end else if (state == S_WR_H || state == S_WR_L ||
                     state == S_MUTE_H || state == S_MUTE_L) begin
            hold_cnt <= hold_cnt + HW'(1);
        end
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // next-state logic; flush aborts a note but never a mute in progress
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (ctrl_run && !empty && !flush) state_nx = S_LOAD;
            S_LOAD:   state_nx = flush ? S_MUTE_H : S_WR_H;
            S_WR_H:   if (flush) state_nx = S_MUTE_H;
                      else if (hold_done) state_nx = S_WR_L;
            S_WR_L:   if (flush) state_nx = S_MUTE_H;
                      else if (hold_done) state_nx = S_PLAY;
            S_PLAY:   if (flush) state_nx = S_MUTE_H;
                      else if (expire) state_nx = (ctrl_run && !empty) ? S_LOAD : S_MUTE_H;
            S_MUTE_H: if (hold_done) state_nx = S_MUTE_L;
            S_MUTE_L: if (hold_done) state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // espectro bus is driven only while a write state is active
    always_comb begin
        sp_cs   = 1'b0;
        sp_wr   = 1'b0;
        sp_addr = 4'h0;
        sp_d_in = 16'h0000;
        case (state)
            S_WR_H:   begin sp_cs = 1'b1; sp_wr = 1'b1; sp_addr = FRH_ADDR; sp_d_in = cur_fh; end
            S_WR_L:   begin sp_cs = 1'b1; sp_wr = 1'b1; sp_addr = FRL_ADDR; sp_d_in = cur_fl; end
            S_MUTE_H: begin sp_cs = 1'b1; sp_wr = 1'b1; sp_addr = FRH_ADDR; end
            S_MUTE_L: begin sp_cs = 1'b1; sp_wr = 1'b1; sp_addr = FRL_ADDR; end
            default: ;
        endcase
    end

    assign sp_rd = 1'b0;
    assign busy  = (state != S_IDLE);

endmodule

// File: tb/tb_espectro_note_sequencer.sv
// Scoreboard bench for espectro_note_sequencer: stimulus pushes expected
// espectro write bursts and CPU read data into queues, a negedge monitor
// collects what the DUT presents and compares in order.
module tb_espectro_note_sequencer;
    localparam int DEPTH = 8, TICK_DIV = 10, WR_HOLD = 4;
    localparam logic [3:0] A_FH = 4'h2, A_FL = 4'h4, A_DUR = 4'h6,
                           A_CTRL = 4'h8, A_ST = 4'hA;

    logic        clk = 1'b0, rst = 1'b1;
    logic        cs = 1'b0, rd = 1'b0, wr = 1'b0;
    logic [3:0]  addr = '0;
    logic [15:0] d_in = '0;
    logic [15:0] d_out, sp_d_in;
    logic        sp_cs, sp_rd, sp_wr, busy;
    logic [3:0]  sp_addr;

    espectro_note_sequencer #(.DEPTH(DEPTH), .TICK_DIV(TICK_DIV), .WR_HOLD(WR_HOLD),
                              .FRH_ADDR(4'h2), .FRL_ADDR(4'h4)) dut (
        .clk(clk), .rst(rst), .cs(cs), .addr(addr), .rd(rd), .wr(wr),
        .d_in(d_in), .d_out(d_out), .sp_cs(sp_cs), .sp_addr(sp_addr),
        .sp_rd(sp_rd), .sp_wr(sp_wr), .sp_d_in(sp_d_in), .busy(busy));

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  addr;
        logic [15:0] data;
        int          len;
        int          gap;   // idle cycles before the burst; -1 = don't care
    } burst_t;

    burst_t      bq[$];
    logic [15:0] rq[$];
    int checks = 0, failures = 0;

    // monitor state
    bit          in_b = 0, b_ok = 0, rd_prev = 0;
    logic [3:0]  b_addr;
    logic [15:0] b_data;
    int          b_len = 0, b_gap = 0, idle_run = 0;

    task automatic close_burst();
        burst_t e;
        checks++;
        if (bq.size() == 0) begin
            failures++;
            $display("FAIL burst_unexpected: got addr=%h data=%h len=%0d, want none", b_addr, b_data, b_len);
        end else begin
            e = bq.pop_front();
            if (b_addr !== e.addr || b_data !== e.data || b_len != e.len ||
                (e.gap >= 0 && b_gap != e.gap) || !b_ok) begin
                failures++;
                $display("FAIL burst: got addr=%h data=%h len=%0d gap=%0d cs_ok=%0b, want addr=%h data=%h len=%0d gap=%0d cs_ok=1",
                         b_addr, b_data, b_len, b_gap, b_ok, e.addr, e.data, e.len, e.gap);
            end
        end
    endtask

    // monitor: espectro write bursts and registered CPU read data
    always @(negedge clk) begin
        logic [15:0] er;
        if (in_b && !(sp_wr && sp_addr == b_addr && sp_d_in == b_data)) begin
            close_burst();
            in_b = 0;
        end
        if (sp_wr) begin
            if (in_b) begin
                b_len++;
                b_ok = b_ok & sp_cs & !sp_rd;
            end else begin
                in_b = 1; b_addr = sp_addr; b_data = sp_d_in;
                b_len = 1; b_gap = idle_run; b_ok = sp_cs & !sp_rd;
            end
            idle_run = 0;
        end else
            idle_run++;

        if (rd_prev) begin
            checks++;
            if (rq.size() == 0) begin
                failures++;
                $display("FAIL read_unexpected: got d_out=%h, want none", d_out);
            end else begin
                er = rq.pop_front();
                if (d_out !== er) begin
                    failures++;
                    $display("FAIL read: got d_out=%h, want %h", d_out, er);
                end
            end
        end
        rd_prev = cs && rd;
    end

    task automatic cpu_wr(input logic [3:0] a, input logic [15:0] d);
        cs = 1; wr = 1; addr = a; d_in = d;
        @(posedge clk); #1;
        cs = 0; wr = 0;
    endtask

    task automatic cpu_rd(input logic [3:0] a, input logic [15:0] exp);
        rq.push_back(exp);
        cs = 1; rd = 1; addr = a;
        @(posedge clk); #1;
        cs = 0; rd = 0;
    endtask

    task automatic push_note(input logic [15:0] fh, input logic [15:0] fl, input logic [15:0] dur);
        cpu_wr(A_FH, fh); cpu_wr(A_FL, fl); cpu_wr(A_DUR, dur);
    endtask

    task automatic exp_b(input logic [3:0] a, input logic [15:0] d, input int len, input int gap);
        burst_t e;
        e.addr = a; e.data = d; e.len = len; e.gap = gap;
        bq.push_back(e);
    endtask

    task automatic exp_note(input logic [15:0] fh, input logic [15:0] fl, input int gap);
        exp_b(4'h2, fh, WR_HOLD, gap);
        exp_b(4'h4, fl, WR_HOLD, 0);
    endtask

    task automatic exp_mute(input int gap);
        exp_b(4'h2, 16'h0, WR_HOLD, gap);
        exp_b(4'h4, 16'h0, WR_HOLD, 0);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        repeat (2) @(posedge clk);
        do begin @(negedge clk); n++; end while (busy && n < 2000);
        checks++;
        if (busy) begin
            failures++;
            $display("FAIL %s_timeout: got busy=1 after %0d cycles, want 0", name, n);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({sp_cs, sp_wr, sp_rd, sp_addr, sp_d_in, busy, d_out} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got cs=%b wr=%b rd=%b addr=%h data=%h busy=%b d_out=%h, want all 0",
                     sp_cs, sp_wr, sp_rd, sp_addr, sp_d_in, busy, d_out);
        end
        @(posedge clk); #1 rst = 0;
        cpu_rd(A_ST, 16'h0004);
        cpu_rd(A_CTRL, 16'h0000);
        cpu_rd(4'h6, 16'h0000);     // write-only address reads 0

        // single note: 4+4 cycle writes, 30-cycle PLAY, mute
        exp_note(16'd0, 16'd100, -1);
        exp_mute(30);
        push_note(16'd0, 16'd100, 16'd3);
        cpu_wr(A_CTRL, 16'h0001);
        wait_idle("t1");

        // three queued notes, back-to-back with LOAD between
        cpu_wr(A_CTRL, 16'h0000);
        exp_note(16'd0, 16'd100, -1);
        exp_note(16'd0, 16'd500, 21);
        exp_note(16'd0, 16'd250, 11);
        exp_mute(40);
        push_note(16'd0, 16'd100, 16'd2);
        push_note(16'd0, 16'd500, 16'd1);
        push_note(16'd0, 16'd250, 16'd4);
        cpu_wr(A_CTRL, 16'h0001);
        wait_idle("t2");
        cpu_rd(A_ST, 16'h0004);

        // DUR=0 plays one tick (run still 1, so push alone starts it)
        exp_note(16'h00A5, 16'h1234, -1);
        exp_mute(10);
        push_note(16'h00A5, 16'h1234, 16'd0);
        wait_idle("t2b");

        // overflow: 9 pushes into 8 entries
        cpu_wr(A_CTRL, 16'h0000);
        cpu_wr(A_FH, 16'd7);
        cpu_wr(A_FL, 16'd8);
        for (int i = 0; i < 9; i++) cpu_wr(A_DUR, 16'(i + 1));
        cpu_rd(A_ST, 16'h008A);
        cpu_rd(A_ST, 16'h0082);
        cpu_wr(A_CTRL, 16'h0002);
        cpu_rd(A_ST, 16'h0004);

        // flush during PLAY of the first of four notes, 5 cycles into PLAY
        for (int i = 0; i < 4; i++) push_note(16'h0012 + 16'(i), 16'h3456, 16'd5);
        exp_note(16'h0012, 16'h3456, -1);
        exp_mute(5);
        cpu_wr(A_CTRL, 16'h0001);
        repeat (14) @(posedge clk);
        #1;
        cpu_wr(A_CTRL, 16'h0002);
        cpu_rd(A_ST, 16'h0005);     // in MUTE_H, queue emptied
        wait_idle("t4");

`ifdef ESPECTRO_SEQ_LOOP_EN
        // loop playback: A,B,A,B then run cleared during the last B
        push_note(16'd0, 16'd111, 16'd1);
        push_note(16'd0, 16'd222, 16'd1);
        exp_note(16'd0, 16'd111, -1);
        exp_note(16'd0, 16'd222, 11);
        exp_note(16'd0, 16'd111, 11);
        exp_note(16'd0, 16'd222, 11);
        exp_mute(10);
        cpu_wr(A_CTRL, 16'h0005);
        repeat (64) @(posedge clk);
        #1;
        cpu_wr(A_CTRL, 16'h0004);
        wait_idle("t6");
        cpu_rd(A_ST, 16'h0020);
        cpu_wr(A_CTRL, 16'h0002);
        cpu_rd(A_ST, 16'h0004);
`else
        // loop bit not built: reads back 0
        cpu_wr(A_CTRL, 16'h0005);
        cpu_rd(A_CTRL, 16'h0001);
        cpu_wr(A_CTRL, 16'h0000);
        cpu_rd(A_CTRL, 16'h0000);
`endif

        // reset during WR_L: FRl burst truncated to 2 cycles
        push_note(16'h0ABC, 16'h0DEF, 16'd2);
        exp_b(4'h2, 16'h0ABC, WR_HOLD, -1);
        exp_b(4'h4, 16'h0DEF, 2, 0);
        cpu_wr(A_CTRL, 16'h0001);
        repeat (7) @(posedge clk);
        #1 rst = 1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({sp_cs, sp_wr, sp_addr, sp_d_in, busy} !== '0) begin
            failures++;
            $display("FAIL reset_mid_write: got cs=%b wr=%b addr=%h data=%h busy=%b, want all 0",
                     sp_cs, sp_wr, sp_addr, sp_d_in, busy);
        end
        @(posedge clk); #1 rst = 0;
        cpu_rd(A_ST, 16'h0004);
        cpu_rd(A_CTRL, 16'h0000);

        repeat (4) @(posedge clk);
        checks++;
        if (bq.size() != 0) begin
            failures++;
            $display("FAIL bursts_missing: got %0d outstanding, want 0", bq.size());
        end
        checks++;
        if (rq.size() != 0) begin
            failures++;
            $display("FAIL reads_missing: got %0d outstanding, want 0", rq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
